// File: rtl/seg_pkg.sv
// Shared types and constants for the dynamic-scan 7-segment scheduler.
package seg_pkg;

  localparam logic [7:0]  SEG_BLANK     = 8'hFF;
  localparam int unsigned DIGITS_DEF    = 6;
  localparam int unsigned DWELL_CYC_DEF = 50000;
  localparam int unsigned BLANK_CYC_DEF = 500;

  typedef enum logic [2:0] {
    IDLE,
    SEND_BLANK,
    BLANK_WAIT,
    SEND_DIGIT,
    DWELL
  } state_e;

endpackage

// File: rtl/seg_pattern_ram.sv
// Per-digit segment pattern store: reset-to-blank registers, one write port, async read.
module seg_pattern_ram
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS = DIGITS_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [2:0] rd_addr,
  output logic [7:0] rd_data_c
);

  logic [7:0] mem_q [DIGITS];
  logic [7:0] mem_d [DIGITS];

  // Addresses at or beyond DIGITS match no entry, so such writes drop out.
  always_comb begin
    for (int i = 0; i < int'(DIGITS); i++) begin
      mem_d[i] = mem_q[i];
      if (wr_en && (wr_addr == 3'(i))) mem_d[i] = wr_data;
    end
  end

  always_comb begin
    rd_data_c = SEG_BLANK;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (rd_addr == 3'(i)) rd_data_c = mem_q[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (rst) mem_q[i] <= SEG_BLANK;
      else     mem_q[i] <= mem_d[i];
    end
  end

endmodule

// File: rtl/seg_scan_sched.sv
// Dynamic-scan scheduler: alternates blank and digit frames to the 74HC595 shifter
// over valid/ready, holding each digit for a dwell time measured from acceptance.
module seg_scan_sched
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS    = DIGITS_DEF,
  parameter int unsigned DWELL_CYC = DWELL_CYC_DEF,
  parameter int unsigned BLANK_CYC = BLANK_CYC_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              scan_en,
  input  logic              blank_all,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [DIGITS-1:0] sel,
  output logic [7:0]        seg,
  output logic [2:0]        cur_digit,
  output logic              frame_done
);

  localparam int unsigned MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int unsigned TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  state_e              state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [2:0]          idx_q, idx_d;
  logic                tx_valid_q, tx_valid_d;
  logic [DIGITS-1:0]   sel_q, sel_d;
  logic [7:0]          seg_q, seg_d;
  logic [2:0]          cur_digit_q, cur_digit_d;
  logic                frame_done_q, frame_done_d;
  logic [7:0]          entry_c;
  logic                xfer_c;

  seg_pattern_ram #(.DIGITS(DIGITS)) u_ram (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .rd_addr   (idx_q),
    .rd_data_c (entry_c)
  );

  assign xfer_c = tx_valid_q & tx_ready;

  // Next-state: offers are registered alongside the state change, so sel/seg
  // only move when a new frame is launched and stay frozen until transfer.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    idx_d        = idx_q;
    tx_valid_d   = tx_valid_q;
    sel_d        = sel_q;
    seg_d        = seg_q;
    cur_digit_d  = cur_digit_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (scan_en) begin
          state_d    = SEND_BLANK;
          tx_valid_d = 1'b1;
          sel_d      = '0;
          seg_d      = SEG_BLANK;
        end
      end
      SEND_BLANK: begin
        if (xfer_c) begin
          state_d    = BLANK_WAIT;
          tx_valid_d = 1'b0;
          timer_d    = '0;
        end
      end
      BLANK_WAIT: begin
        if (timer_q == TMR_W'(BLANK_CYC - 1)) begin
          if (!scan_en) begin
            state_d = IDLE;
          end else begin
            state_d    = SEND_DIGIT;
            tx_valid_d = 1'b1;
            sel_d      = DIGITS'(1) << idx_q;
            seg_d      = blank_all ? SEG_BLANK : entry_c;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      SEND_DIGIT: begin
        if (xfer_c) begin
          state_d     = DWELL;
          tx_valid_d  = 1'b0;
          cur_digit_d = idx_q;
          timer_d     = '0;
        end
      end
      DWELL: begin
        if (timer_q == TMR_W'(DWELL_CYC - 1)) begin
          // The blank frame is always sent so a stopped scan parks dark.
          state_d      = SEND_BLANK;
          tx_valid_d   = 1'b1;
          sel_d        = '0;
          seg_d        = SEG_BLANK;
          frame_done_d = (idx_q == 3'(DIGITS - 1));
          idx_d        = (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      idx_q        <= 3'd0;
      tx_valid_q   <= 1'b0;
      sel_q        <= '0;
      seg_q        <= SEG_BLANK;
      cur_digit_q  <= 3'd0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      idx_q        <= idx_d;
      tx_valid_q   <= tx_valid_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      cur_digit_q  <= cur_digit_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign sel        = sel_q;
  assign seg        = seg_q;
  assign cur_digit  = cur_digit_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_sched.sv
// Randomized bench for seg_scan_sched against a frame-timeline reference model.
module tb_seg_scan_sched;

  localparam int unsigned DIGITS = 6;
  localparam int unsigned DWELL  = 20;
  localparam int unsigned BLANK  = 4;

  logic              sys_clk   = 1'b0;
  logic              sys_rst   = 1'b1;
  logic              wr_en     = 1'b0;
  logic [2:0]        wr_addr   = 3'd0;
  logic [7:0]        wr_data   = 8'h00;
  logic              scan_en   = 1'b0;
  logic              blank_all = 1'b0;
  logic              tx_ready  = 1'b1;
  logic              tx_valid;
  logic [DIGITS-1:0] sel;
  logic [7:0]        seg;
  logic [2:0]        cur_digit;
  logic              frame_done;

  seg_scan_sched #(.DIGITS(DIGITS), .DWELL_CYC(DWELL), .BLANK_CYC(BLANK)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .scan_en    (scan_en),
    .blank_all  (blank_all),
    .tx_ready   (tx_ready),
    .tx_valid   (tx_valid),
    .sel        (sel),
    .seg        (seg),
    .cur_digit  (cur_digit),
    .frame_done (frame_done)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model: a timeline of frame offers, not a state machine.
  logic [7:0]        m_store [DIGITS];
  int                m_idx, m_cur;
  bit                idle, in_offer, offer_is_digit, next_digit;
  int                idle_since, offer_due, done_due;
  logic [DIGITS-1:0] exp_sel;
  logic [7:0]        exp_seg;

  // Explicit test-plan checks layered on top of the model.
  bit         chk_period, chk_pattern, expect_resume;
  int         last_digit_rise, last_done;
  logic [7:0] pat_tbl [DIGITS];

  // Drive requests applied at the next tick.
  logic       d_rst = 1'b1, d_scan = 1'b0, d_blank = 1'b0, d_ready = 1'b1, d_wr_en = 1'b0;
  logic [2:0] d_wr_addr = 3'd0;
  logic [7:0] d_wr_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(DIGITS); i++) m_store[i] = 8'hFF;
    m_idx = 0; m_cur = 0; idle = 1'b1; idle_since = cyc; in_offer = 1'b0;
    next_digit = 1'b0; offer_due = -1; done_due = -1;
  endtask

  task automatic start_offer(input bit digit);
    in_offer = 1'b1;
    offer_is_digit = digit;
    if (digit) begin
      exp_sel = DIGITS'(1) << m_idx;
      exp_seg = blank_all ? 8'hFF : m_store[m_idx];
      if (chk_period && last_digit_rise >= 0) check("digit_period", 32'(cyc - last_digit_rise), 32'd26);
      last_digit_rise = cyc;
      if (chk_pattern) check("pattern_seg", 32'(exp_seg), 32'(pat_tbl[m_idx]));
      if (expect_resume) begin
        check("resume_sel", 32'(exp_sel), 32'(6'b001000));
        expect_resume = 1'b0;
      end
    end else begin
      exp_sel = '0;
      exp_seg = 8'hFF;
    end
  endtask

  // One cycle: check what the last edge produced, then drive the next inputs.
  task automatic tick();
    @(negedge sys_clk);
    cyc++;
    if (sys_rst) begin
      model_reset();
      check("rst_valid", 32'(tx_valid), 32'd0);
      check("rst_sel", 32'(sel), 32'd0);
      check("rst_seg", 32'(seg), 32'hFF);
      check("rst_cur", 32'(cur_digit), 32'd0);
      check("rst_done", 32'(frame_done), 32'd0);
    end else begin
      if (!in_offer) begin
        if (idle) begin
          if (cyc > idle_since && scan_en) begin
            idle = 1'b0;
            start_offer(1'b0);
          end
        end else if (cyc == offer_due) begin
          if (next_digit && !scan_en) begin
            idle = 1'b1;
            idle_since = cyc;
          end else begin
            start_offer(next_digit);
          end
        end
      end
      check("tx_valid", 32'(tx_valid), 32'(in_offer));
      if (in_offer) begin
        check("sel", 32'(sel), 32'(exp_sel));
        check("seg", 32'(seg), 32'(exp_seg));
      end
      check("frame_done", 32'(frame_done), 32'(cyc == done_due));
      check("cur_digit", 32'(cur_digit), 32'(m_cur));
      if (frame_done && chk_period) begin
        if (last_done >= 0) check("done_period", 32'(cyc - last_done), 32'd156);
        last_done = cyc;
      end
      if (wr_en && int'(wr_addr) < int'(DIGITS)) m_store[wr_addr] = wr_data;
    end
    sys_rst   = d_rst;
    scan_en   = d_scan;
    blank_all = d_blank;
    tx_ready  = d_ready;
    wr_en     = d_wr_en;
    wr_addr   = d_wr_addr;
    wr_data   = d_wr_data;
    d_wr_en   = 1'b0;
    if (!sys_rst && in_offer && tx_ready) begin
      in_offer = 1'b0;
      if (offer_is_digit) begin
        m_cur      = m_idx;
        offer_due  = cyc + 1 + int'(DWELL);
        done_due   = (m_idx == int'(DIGITS) - 1) ? offer_due : -1;
        m_idx      = (m_idx + 1) % int'(DIGITS);
        next_digit = 1'b0;
      end else begin
        offer_due  = cyc + 1 + int'(BLANK);
        next_digit = 1'b1;
      end
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    d_wr_en = 1'b1; d_wr_addr = a; d_wr_data = d;
    tick();
  endtask

  initial begin
    bit found;
    last_digit_rise = -1; last_done = -1;
    chk_period = 1'b0; chk_pattern = 1'b0; expect_resume = 1'b0;
    exp_sel = '0; exp_seg = 8'hFF;
    model_reset();
    pat_tbl[0] = 8'hC0;
    for (int i = 1; i < int'(DIGITS); i++) pat_tbl[i] = 8'hFF;
    pat_tbl[DIGITS-1] = 8'hF9;

    // Empty store, free-running scan: fixed digit and frame periods.
    repeat (2) tick();
    d_rst = 1'b0; d_scan = 1'b1; chk_period = 1'b1;
    repeat (400) tick();
    chk_period = 1'b0;

    // Patterns on the end digits; an out-of-range write must not land anywhere.
    do_write(3'd0, 8'hC0);
    do_write(3'd5, 8'hF9);
    do_write(3'd7, 8'h55);
    repeat (30) tick();
    chk_pattern = 1'b1;
    repeat (300) tick();
    chk_pattern = 1'b0;

    // Ten-cycle stall on a digit frame.
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (!in_offer && next_digit && !idle) found = 1'b1;
    end
    check("stall_setup", 32'(found), 32'd1);
    d_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (in_offer && offer_is_digit) found = 1'b1;
    end
    check("stall_offer", 32'(found), 32'd1);
    repeat (10) tick();
    d_ready = 1'b1;
    repeat (60) tick();

    // Stop scanning during digit 2's dwell, then resume at digit 3.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick();
      if (!in_offer && !next_digit && !idle && m_cur == 2 && offer_due - cyc > 5) found = 1'b1;
    end
    check("dwell2_found", 32'(found), 32'd1);
    d_scan = 1'b0;
    repeat (60) tick();
    check("park_valid", 32'(tx_valid), 32'd0);
    check("park_seg", 32'(seg), 32'hFF);
    d_scan = 1'b1; expect_resume = 1'b1;
    repeat (60) tick();
    check("resume_seen", 32'(expect_resume), 32'd0);

    // blank_all raised mid-scan.
    d_blank = 1'b1;
    repeat (200) tick();
    d_blank = 1'b0;

    // Random traffic: stalls, scan/blank toggles, writes, occasional reset.
    repeat (3000) begin
      d_ready = ($urandom_range(3) != 0);
      if ($urandom_range(199) == 0) d_scan = ~d_scan;
      if ($urandom_range(149) == 0) d_blank = ~d_blank;
      if ($urandom_range(7) == 0) begin
        d_wr_en = 1'b1; d_wr_addr = 3'($urandom_range(7)); d_wr_data = 8'($urandom);
      end
      d_rst = ($urandom_range(999) == 0);
      tick();
    end
    d_rst = 1'b0; d_blank = 1'b0; d_scan = 1'b1;

    // Reset while a frame is offered and stalled; store must come back blank.
    d_ready = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      tick();
      if (in_offer) found = 1'b1;
    end
    check("rst_setup", 32'(found), 32'd1);
    d_rst = 1'b1;
    tick();
    d_rst = 1'b0; d_ready = 1'b1;
    tick();
    repeat (200) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_sched.md
Name: seg_scan_sched

Overview:
- Dynamic-scan scheduler for the six-digit 7-segment display driven through the 74HC595 shifter (hc595_ctrl).
- Holds one segment pattern per digit, written by any host logic.
- Time-multiplexes the digits: a blanking frame, then a digit frame, then a dwell time.
- Hands each frame to the shifter over a valid/ready handshake. Replaces seg_static in dynamic display tops.

Parameters:
- DIGITS, 6, number of digits scanned; sel width; 1..8.
- DWELL_CYC, 50000, sys_clk cycles a digit frame stays shown after acceptance (1 ms at 50 MHz); >=1.
- BLANK_CYC, 500, cycles the blank frame stays shown before the next digit frame (anti-ghosting); >=1.

Ports:
- sys_clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write strobe for the pattern store.
- wr_addr  in  3  digit index to write.
- wr_data  in  8  segment pattern, active-low, bit7 = dp.
- scan_en  in  1  1 = scanning runs; 0 = park display blank.
- blank_all  in  1  1 = digit frames sent with seg=8'hFF (display dark, timing unchanged).
- tx_ready  in  1  shifter can accept a frame.
- tx_valid  out  1  frame on sel/seg is offered.
- sel  out  DIGITS  one-hot digit select, active-high; 0 = none.
- seg  out  8  segment pattern of the offered frame.
- cur_digit  out  3  index of the digit currently shown.
- frame_done  out  1  one-cycle pulse when the last digit's dwell ends.

Behaviour:
- Reset (sys_rst=1 at an edge, any state, including mid-handshake):
  - all store entries = 8'hFF; index = 0; state IDLE.
  - tx_valid=0, sel=0, seg=8'hFF, cur_digit=0, frame_done=0.
- Store writes:
  - wr_en with wr_addr<DIGITS writes the next cycle; wr_addr>=DIGITS is ignored.
  - A write to the digit being captured in the same cycle is NOT seen; the old value is sent.
- Handshake:
  - Transfer occurs on an edge where tx_valid&tx_ready.
  - Once tx_valid rises, tx_valid, sel and seg are held stable until transfer.
  - tx_valid drops the cycle after transfer.
  - No frame is withdrawn; scan_en and blank_all changes never abort an offered frame.
- States:
  - IDLE: tx_valid=0. scan_en=1 -> SEND_BLANK.
  - SEND_BLANK: offer sel=0, seg=8'hFF. On transfer, timer=0 -> BLANK_WAIT.
  - BLANK_WAIT: count BLANK_CYC cycles. At the end: if scan_en=0 -> IDLE; else capture the store entry for index -> SEND_DIGIT.
  - SEND_DIGIT: offer sel=1<<index, seg=(blank_all ? 8'hFF : entry). blank_all is sampled at capture. On transfer, cur_digit=index, timer=0 -> DWELL.
  - DWELL: count DWELL_CYC cycles. At the end:
    - index = (index==DIGITS-1) ? 0 : index+1.
    - frame_done pulses iff the old index was DIGITS-1.
    - -> SEND_BLANK; if scan_en=0 this blank frame parks the display.
- scan_en=0 in any state: the current state completes. The next BLANK_WAIT end goes to IDLE, so the display always parks dark. index is kept, and scanning resumes at that digit.
- Timer:
  - Counts from acceptance (cycle after transfer = count 0); ends at count N-1.
  - Width clog2(max(DWELL_CYC,BLANK_CYC)); no wrap before the end is reached.
- tx_ready stalls only stretch the SEND states; dwell and blank times are measured from acceptance.
- Digit period = BLANK_CYC + DWELL_CYC + 2 + stall cycles.

Decomposition:
- Package seg_pkg:
  - SEG_BLANK = 8'hFF.
  - FSM state enum (IDLE, SEND_BLANK, BLANK_WAIT, SEND_DIGIT, DWELL).
  - Default DWELL_CYC/BLANK_CYC constants.
- One natural sub-module, seg_pattern_ram: DIGITS x 8 register store with reset-to-blank, one write port and one async read port.
- FSM, timer and handshake stay in seg_scan_sched.

Test Plan:
Run with DIGITS=6, DWELL_CYC=20, BLANK_CYC=4, tx_ready=1 unless stated.
1. Reset, then scan_en=1 with an empty store. Frames alternate blank(sel=0, seg=FF) and sel=000001..100000 with seg=FF. Digit frames are 26 cycles apart. frame_done pulses once per 156 cycles.
2. Write addr0=8'hC0 and addr5=8'hF9, then scan. Frame sel=000001 carries seg=C0; frame sel=100000 carries F9; the others carry FF. Write addr=7 -> no entry changes.
3. Hold tx_ready=0 for 10 cycles during SEND_DIGIT. tx_valid/sel/seg stay stable all 10 cycles. After the transfer, the dwell still lasts 20 cycles.
4. scan_en=0 during DWELL of digit 2. The dwell finishes, one blank frame transfers, then IDLE with tx_valid=0. Re-enable -> the first digit frame is sel=001000 (index 3).
5. blank_all=1 asserted mid-DWELL. The current frame is unchanged; subsequent digit frames have seg=FF with one-hot sel still cycling.
6. sys_rst=1 while tx_valid=1 and tx_ready=0. The next cycle gives tx_valid=0, sel=0, seg=FF, cur_digit=0, and store entries read FF.
